ro_scan_mux: RTL and testbench

Parametrised N-to-1 ring-oscillator selector with a built-in measurement sequencer. It sits between the RO array and the edge counter. It routes one oscillator at a time to `ro_out`, and holds the output low while the selection settles. It then opens a measurement window of fixed length. In scan mode it steps through a channel range on its own, one window per channel.

---
 rtl/ro_puf_pkg.sv | 13 +
 rtl/ro_gate_mux.sv | 15 +
 rtl/ro_scan_mux.sv | 146 ++++++++++++++
 tb/tb_ro_scan_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state and mode encodings for the RO scan/measurement blocks.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WINDOW = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/ro_gate_mux.sv
// ro_gate_mux: N_IN:1 oscillator select followed by an AND gate; kept as its own
// hierarchy so the glitch-sensitive path can be marked dont_touch.
module ro_gate_mux #(
    parameter int N_IN  = 16,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] select,
    input  logic             gate,
    output logic             out
);

    assign out = in[select] & gate;

endmodule

// File: rtl/ro_scan_mux.sv
// ro_scan_mux: routes one ring oscillator to ro_out with a settle/measure sequencer
// supporting a single direct window or an automatic scan over a channel range.
module ro_scan_mux
    import ro_puf_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int SEL_W  = $clog2(N_IN),
    parameter int SETTLE = 8,
    parameter int DWELL  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  ro_in,
    input  logic             mode,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [SEL_W-1:0] sel_idx,
    input  logic [SEL_W-1:0] scan_first,
    input  logic [SEL_W-1:0] scan_last,
    input  logic             abort,
    output logic             ro_out,
    output logic [SEL_W-1:0] ch_active,
    output logic             win_open,
    output logic             win_done,
    output logic             scan_done,
    output logic             err
);

    localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] ch_q, ch_d, last_q, last_d, ch_next;
    logic             mode_q, mode_d, gate_q, gate_d;
    logic             win_done_q, win_done_d, scan_done_q, scan_done_d, err_q, err_d;
    logic             bad, cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign ch_next  = (ch_q == SEL_W'(N_IN - 1)) ? '0 : ch_q + SEL_W'(1);
    assign bad      = (mode == MODE_SCAN) ? (32'(scan_first) >= N_IN || 32'(scan_last) >= N_IN)
                                          : (32'(sel_idx) >= N_IN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        last_d      = last_q;
        mode_d      = mode_q;
        gate_d      = gate_q;
        win_done_d  = 1'b0;
        scan_done_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && bad) begin
                    err_d = 1'b1;
                end else if (sel_valid) begin
                    ch_d    = (mode == MODE_SCAN) ? scan_first : sel_idx;
                    last_d  = scan_last;
                    mode_d  = mode;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    state_d = S_WINDOW;
                    gate_d  = 1'b1;
                    cnt_d   = CW'(DWELL - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WINDOW: begin
                // abort wins over completion, so a cancelled window never reports done
                if (abort) begin
                    state_d = S_IDLE;
                    gate_d  = 1'b0;
                end else if (cnt_zero) begin
                    gate_d     = 1'b0;
                    win_done_d = 1'b1;
                    if (mode_q == MODE_SCAN && ch_q != last_q) begin
                        ch_d    = ch_next;
                        cnt_d   = CW'(SETTLE - 1);
                        state_d = S_SETTLE;
                    end else begin
                        scan_done_d = (mode_q == MODE_SCAN);
                        state_d     = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            last_q      <= '0;
            mode_q      <= MODE_DIRECT;
            gate_q      <= 1'b0;
            win_done_q  <= 1'b0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            gate_q      <= gate_d;
            win_done_q  <= win_done_d;
            scan_done_q <= scan_done_d;
            err_q       <= err_d;
        end
    end

    assign sel_ready = (state_q == S_IDLE);
    assign ch_active = ch_q;
    assign win_open  = gate_q;
    assign win_done  = win_done_q;
    assign scan_done = scan_done_q;
    assign err       = err_q;

    (* dont_touch = "true" *)
    ro_gate_mux #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_gate_mux (
        .in     (ro_in),
        .select (ch_q),
        .gate   (gate_q),
        .out    (ro_out)
    );

endmodule

// File: tb/tb_ro_scan_mux.sv
// tb_ro_scan_mux: directed scenario tasks for ro_scan_mux (N_IN=16 main instance,
// N_IN=12 instance for out-of-range rejection), SETTLE=8, DWELL=16.
module tb_ro_scan_mux;

    localparam int S = 8;
    localparam int D = 16;
    localparam int P = S + D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ro_in = '0;
    logic [11:0] ro_in12;
    logic        mode = 1'b0, sel_valid = 1'b0, v12 = 1'b0, abort = 1'b0;
    logic [3:0]  sel_idx = '0, scan_first = '0, scan_last = '0;

    logic       sel_ready, ro_out, win_open, win_done, scan_done, err;
    logic [3:0] ch_active;
    logic       rdy12, ro12, wo12, wd12, sd12, er12;
    logic [3:0] ch12;

    int n_chk = 0;
    int n_fail = 0;

    assign ro_in12 = ro_in[11:0];

    always #5 clk = ~clk;

    ro_scan_mux #(.N_IN(16), .SEL_W(4), .SETTLE(S), .DWELL(D)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .mode(mode), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .sel_idx(sel_idx), .scan_first(scan_first),
        .scan_last(scan_last), .abort(abort), .ro_out(ro_out), .ch_active(ch_active),
        .win_open(win_open), .win_done(win_done), .scan_done(scan_done), .err(err)
    );

    ro_scan_mux #(.N_IN(12), .SEL_W(4), .SETTLE(S), .DWELL(D)) dut12 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in12), .mode(mode), .sel_valid(v12),
        .sel_ready(rdy12), .sel_idx(sel_idx), .scan_first(scan_first),
        .scan_last(scan_last), .abort(1'b0), .ro_out(ro12), .ch_active(ch12),
        .win_open(wo12), .win_done(wd12), .scan_done(sd12), .err(er12)
    );

    task automatic start(input logic m, input logic [3:0] idx, input logic [3:0] f, input logic [3:0] l);
        @(negedge clk);
        mode = m; sel_idx = idx; scan_first = f; scan_last = l; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", sel_ready); end
        n_chk++; if (ch_active !== 4'd0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", ch_active); end
        n_chk++; if ({ro_out, win_open, win_done, scan_done, err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outs got %b exp 00000", {ro_out, win_open, win_done, scan_done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        logic open;
        start(1'b0, 4'd5, 4'd0, 4'd0);
        for (int c = 0; c <= P; c++) begin
            if (c > 0) @(negedge clk);
            ro_in = 16'($urandom);
            #1;
            open = (c >= S) && (c < P);
            n_chk++; if (win_open !== open) begin n_fail++; $display("FAIL direct_open c=%0d got %b exp %b", c, win_open, open); end
            n_chk++; if (ro_out !== (ro_in[5] & open)) begin n_fail++; $display("FAIL direct_ro c=%0d got %b exp %b", c, ro_out, ro_in[5] & open); end
            n_chk++; if (ch_active !== 4'd5) begin n_fail++; $display("FAIL direct_ch c=%0d got %0d exp 5", c, ch_active); end
            n_chk++; if (win_done !== (c == P)) begin n_fail++; $display("FAIL direct_done c=%0d got %b exp %b", c, win_done, c == P); end
            n_chk++; if (sel_ready !== (c == P)) begin n_fail++; $display("FAIL direct_ready c=%0d got %b exp %b", c, sel_ready, c == P); end
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] seq [4];
        logic [3:0] ech;
        seq = '{4'd14, 4'd15, 4'd0, 4'd1};
        start(1'b1, 4'd0, 4'd14, 4'd1);
        for (int c = 0; c <= 4 * P; c++) begin
            if (c > 0) @(negedge clk);
            ech = seq[(c < 4 * P) ? c / P : 3];
            n_chk++; if (ch_active !== ech) begin n_fail++; $display("FAIL scan_ch c=%0d got %0d exp %0d", c, ch_active, ech); end
            n_chk++; if (win_done !== (c > 0 && c % P == 0)) begin n_fail++; $display("FAIL scan_wdone c=%0d got %b", c, win_done); end
            n_chk++; if (scan_done !== (c == 4 * P)) begin n_fail++; $display("FAIL scan_sdone c=%0d got %b", c, scan_done); end
            n_chk++; if (win_open !== (c < 4 * P && c % P >= S)) begin n_fail++; $display("FAIL scan_open c=%0d got %b", c, win_open); end
        end
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL scan_ready got %b exp 1", sel_ready); end
    endtask

    task automatic test_err();
        @(negedge clk);
        mode = 1'b0; sel_idx = 4'd3; v12 = 1'b1;
        @(negedge clk);
        v12 = 1'b0;
        repeat (P) @(negedge clk);
        n_chk++; if (wd12 !== 1'b1 || ch12 !== 4'd3) begin n_fail++; $display("FAIL err_setup got done=%b ch=%0d exp 1/3", wd12, ch12); end
        sel_idx = 4'd13; v12 = 1'b1;
        @(negedge clk);
        v12 = 1'b0;
        n_chk++; if (er12 !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", er12); end
        n_chk++; if (rdy12 !== 1'b1) begin n_fail++; $display("FAIL err_ready got %b exp 1", rdy12); end
        n_chk++; if (ch12 !== 4'd3) begin n_fail++; $display("FAIL err_ch got %0d exp 3", ch12); end
        ro_in = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_chk++; if (er12 !== 1'b0) begin n_fail++; $display("FAIL err_once c=%0d got %b exp 0", c, er12); end
            n_chk++; if (ro12 !== 1'b0 || wo12 !== 1'b0) begin n_fail++; $display("FAIL err_gate c=%0d got ro=%b open=%b exp 0", c, ro12, wo12); end
            n_chk++; if (rdy12 !== 1'b1) begin n_fail++; $display("FAIL err_idle c=%0d got %b exp 1", c, rdy12); end
        end
    endtask

    task automatic test_abort();
        start(1'b1, 4'd0, 4'd2, 4'd5);
        repeat (41) @(negedge clk);
        n_chk++; if (ch_active !== 4'd3 || win_open !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre got ch=%0d open=%b exp 3/1", ch_active, win_open); end
        abort = 1'b1; ro_in = '1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_chk++; if (win_open !== 1'b0 || ro_out !== 1'b0) begin n_fail++; $display("FAIL abort_gate got open=%b ro=%b exp 0", win_open, ro_out); end
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b exp 1", sel_ready); end
        n_chk++; if (ch_active !== 4'd3) begin n_fail++; $display("FAIL abort_ch got %0d exp 3", ch_active); end
        for (int c = 0; c < 30; c++) begin
            n_chk++; if (win_done !== 1'b0 || scan_done !== 1'b0) begin
                n_fail++; $display("FAIL abort_nodone c=%0d got wd=%b sd=%b exp 0", c, win_done, scan_done); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        start(1'b0, 4'd7, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        n_chk++; if (ch_active !== 4'd7 || sel_ready !== 1'b0) begin
            n_fail++; $display("FAIL arst_pre got ch=%0d ready=%b exp 7/0", ch_active, sel_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b exp 1", sel_ready); end
        n_chk++; if (ch_active !== 4'd0) begin n_fail++; $display("FAIL arst_ch got %0d exp 0", ch_active); end
        n_chk++; if ({ro_out, win_open, win_done, scan_done, err} !== 5'b0) begin
            n_fail++; $display("FAIL arst_outs got %b exp 00000", {ro_out, win_open, win_done, scan_done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        test_direct();
    endtask

    task automatic test_back_to_back();
        logic open;
        @(negedge clk);
        mode = 1'b0; sel_idx = 4'd5; sel_valid = 1'b1;
        @(negedge clk);
        sel_idx = 4'd9;
        for (int c = 0; c <= P; c++) begin
            if (c > 0) @(negedge clk);
            ro_in = 16'($urandom);
            #1;
            open = (c >= S) && (c < P);
            n_chk++; if (ch_active !== 4'd5) begin n_fail++; $display("FAIL hold_ch c=%0d got %0d exp 5", c, ch_active); end
            n_chk++; if (ro_out !== (ro_in[5] & open)) begin n_fail++; $display("FAIL hold_ro c=%0d got %b exp %b", c, ro_out, ro_in[5] & open); end
        end
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready got %b exp 1", sel_ready); end
        @(negedge clk);
        n_chk++; if (ch_active !== 4'd9 || sel_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_next got ch=%0d ready=%b exp 9/0", ch_active, sel_ready); end
        sel_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL hold_abort got %b exp 1", sel_ready); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_err();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
